// File: rtl/div_if.sv
// Request/response bundle between the EX-stage pipeline (master) and the
// iterative divider (slave).
interface div_if #(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/div_seq.sv
// Restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per
// clock, with RISC-V divide-by-zero and signed-overflow results.
module div_seq #(
  parameter int XLEN      = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            op_rem_q, op_rem_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic            special_q, special_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic            accept, is_signed, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, quot_fix, rem_fix, fix_res;
  logic [XLEN+1:0] shifted, diff;

  // Operand classification on the request inputs, used only in the accept cycle.
  assign accept    = bus.in_valid & in_ready_q;
  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.in1[XLEN-1];
  assign b_neg     = is_signed & bus.in2[XLEN-1];
  assign a_mag     = a_neg ? -bus.in1 : bus.in1;
  assign b_mag     = b_neg ? -bus.in2 : bus.in2;
  assign div0      = (bus.in2 == '0);
  assign ovf       = is_signed & (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.in2 == '1);
  assign special   = div0 | ovf;
  assign spec_res  = bus.op[1] ? (div0 ? bus.in1 : '0)
                               : (div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign shifted  = {rem_q, quot_q[XLEN-1]};
  assign diff     = shifted - {2'b00, dvsr_q};

  assign quot_fix = neg_quot_q ? -quot_q : quot_q;
  assign rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign fix_res  = (!FAST_SPEC && special_q) ? spec_res_q
                                              : (op_rem_q ? rem_fix : quot_fix);

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    spec_res_d  = spec_res_q;
    result_d    = result_q;
    op_rem_d    = op_rem_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    special_d   = special_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_rem_d   = bus.op[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          quot_d     = a_mag;
          dvsr_d     = b_mag;
          rem_d      = '0;
          count_d    = '0;
          special_d  = special;
          spec_res_d = spec_res;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (FAST_SPEC && special) begin
            result_d    = spec_res;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[XLEN+1]) begin
          rem_d  = diff[XLEN:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d  = shifted[XLEN:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        result_d    = fix_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pipeline redirect wins over everything, including a pending accept.
    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      busy_d      = 1'b0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      spec_res_q  <= '0;
      result_q    <= '0;
      op_rem_q    <= 1'b0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      special_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      dvsr_q      <= dvsr_d;
      spec_res_q  <= spec_res_d;
      result_q    <= result_d;
      op_rem_q    <= op_rem_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      special_q   <= special_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RV32M corner cases, DONE hold,
// flush and async reset, then random operations against a 64-bit arithmetic model.
module tb_div_seq;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  div_if #(.XLEN(32)) bus ();

  div_seq #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V reference: 64-bit arithmetic cannot overflow, and SV division truncates toward zero.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 16));
      4:       return -32'($urandom_range(1, 16));
      default: return $urandom;
    endcase
  endfunction

  // Presents one request and returns just after the accept edge, with inputs scrambled.
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int waitc = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.in1      = a;
    bus.in2      = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom);
    bus.in1      = $urandom;
    bus.in2      = $urandom;
  endtask

  // Latency is counted in rising edges after the accept edge.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    int lat = 0;
    start(op, a, b);
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(op, a, b)));
    check({tag, "_result"}, bus.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, bus.result, exp);
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_release_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_release_busy"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;

    #12;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    do_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    do_op("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    do_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
    do_op("hold5", OP_DIVU, 32'd1000, 32'd10, 32'd100, 5);

    // Flush while iterating (count==10) with a competing request.
    start(OP_DIVU, 32'd12345, 32'd17);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre_flush_busy", 32'(bus.busy), 32'd1);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.in1      = 32'd50;
    bus.in2      = 32'd5;
    @(posedge clk);
    #1;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("flush_no_accept", 32'(bus.busy), 32'd0);
    do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 0);

    // Asynchronous reset in the middle of an iteration.
    start(OP_DIV, 32'hDEAD_BEEF, 32'd3);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = pick();
      b  = pick();
      do_op($sformatf("rand%0d", i), op, a, b, ref_div(op, a, b), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
